// File: rtl/parking_exit_controller_if.sv
// ============================================================================
//  Module      : parking_exit_controller_if
//  Description : Sensor, payment and status bundle for the exit controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface parking_exit_controller_if;
    logic        entry_done;
    logic        sense_exit;
    logic        coin_valid;
    logic        sense_clear;
    logic        attendant_ack;
    logic        gate_open;
    logic        green_light;
    logic        red_light;
    logic [6:0]  hex_1;
    logic [6:0]  hex_2;
    logic [3:0]  occupancy;
    logic        full;
    logic        coin_reject;
    logic        refund;
    logic [3:0]  refund_coins;
    logic [15:0] exits_total;

    modport master (
        output entry_done, sense_exit, coin_valid, sense_clear, attendant_ack,
        input  gate_open, green_light, red_light, hex_1, hex_2, occupancy,
               full, coin_reject, refund, refund_coins, exits_total
    );

    modport slave (
        input  entry_done, sense_exit, coin_valid, sense_clear, attendant_ack,
        output gate_open, green_light, red_light, hex_1, hex_2, occupancy,
               full, coin_reject, refund, refund_coins, exits_total
    );
endinterface

`default_nettype wire

// File: rtl/parking_exit_controller.sv
// ============================================================================
//  Module      : parking_exit_controller
//  Description : Exit-side fee collection, gate control, occupancy and alarm.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module parking_exit_controller #(
    parameter int CAPACITY         = 8,
    parameter int FEE              = 3,
    parameter int PAY_TIMEOUT      = 16,
    parameter int GATE_OPEN_CYCLES = 8
) (
    input  wire                           clk,
    input  wire                           rst,
    parking_exit_controller_if.slave      exit_io
);
    localparam int TMAX = (PAY_TIMEOUT > GATE_OPEN_CYCLES) ? PAY_TIMEOUT : GATE_OPEN_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [6:0] HEX_OFF = 7'b0000000;
    localparam logic [6:0] HEX_P   = 7'b1110011;
    localparam logic [6:0] HEX_A   = 7'b1110111;
    localparam logic [6:0] HEX_6   = 7'b1111101;
    localparam logic [6:0] HEX_0   = 7'b0111111;
    localparam logic [6:0] HEX_L   = 7'b0111000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        OPEN    = 2'd2,
        ALARM   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    coins_q, coins_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    occ_q, occ_d;
    logic [15:0]   exits_q, exits_d;
    logic          gate_q, gate_d;
    logic          green_q, green_d;
    logic          red_q, red_d;
    logic [6:0]    hex1_q, hex1_d;
    logic [6:0]    hex2_q, hex2_d;
    logic          reject_q, reject_d;
    logic          refund_q, refund_d;
    logic [3:0]    rcoins_q, rcoins_d;
    logic          exit_evt;
    logic [4:0]    coin_sum;

    assign coin_sum = {1'b0, coins_q} + {4'd0, exit_io.coin_valid};

    always_comb begin
        state_d  = state_q;
        coins_d  = coins_q;
        timer_d  = timer_q;
        refund_d = 1'b0;
        rcoins_d = 4'd0;
        exit_evt = 1'b0;
        case (state_q)
            IDLE: begin
                if (exit_io.sense_exit) begin
                    coins_d = 4'd0;
                    timer_d = '0;
                    state_d = (occ_q != 4'd0) ? COLLECT : ALARM;
                end
            end
            COLLECT: begin
                coins_d = coin_sum[3:0];
                timer_d = exit_io.coin_valid ? '0 : timer_q + 1'b1;
                if (coin_sum >= 5'(FEE)) begin
                    state_d = OPEN;
                    coins_d = 4'd0;
                    timer_d = '0;
                end else if (!exit_io.sense_exit) begin
                    state_d  = IDLE;
                    refund_d = 1'b1;
                    rcoins_d = coin_sum[3:0];
                end else if (!exit_io.coin_valid && timer_q == TW'(PAY_TIMEOUT - 1)) begin
                    state_d  = ALARM;
                    refund_d = 1'b1;
                    rcoins_d = coin_sum[3:0];
                end
            end
            OPEN: begin
                timer_d = timer_q + 1'b1;
                if (exit_io.sense_clear) begin
                    state_d  = IDLE;
                    exit_evt = 1'b1;
                end else if (timer_q == TW'(GATE_OPEN_CYCLES - 1)) begin
                    state_d = ALARM;
                end
            end
            default: begin
                if (exit_io.attendant_ack) begin
                    state_d = IDLE;
                end
            end
        endcase

        // A simultaneous entry and exit cancel out, so a full car park stays full.
        occ_d   = occ_q;
        exits_d = exits_q;
        if (exit_evt) begin
            exits_d = exits_q + 16'd1;
            if (!exit_io.entry_done) begin
                occ_d = occ_q - 4'd1;
            end
        end else if (exit_io.entry_done && occ_q < 4'(CAPACITY)) begin
            occ_d = occ_q + 4'd1;
        end

        reject_d = exit_io.coin_valid && (state_q != COLLECT);

        gate_d  = (state_d == OPEN);
        green_d = (state_d == OPEN);
        red_d   = (state_d == ALARM) && ((state_q == ALARM) ? ~red_q : 1'b1);
        case (state_d)
            COLLECT: begin hex1_d = HEX_P;   hex2_d = HEX_A;   end
            OPEN:    begin hex1_d = HEX_6;   hex2_d = HEX_0;   end
            ALARM:   begin hex1_d = HEX_A;   hex2_d = HEX_L;   end
            default: begin hex1_d = HEX_OFF; hex2_d = HEX_OFF; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            coins_q  <= 4'd0;
            timer_q  <= '0;
            occ_q    <= 4'd0;
            exits_q  <= 16'd0;
            gate_q   <= 1'b0;
            green_q  <= 1'b0;
            red_q    <= 1'b0;
            hex1_q   <= HEX_OFF;
            hex2_q   <= HEX_OFF;
            reject_q <= 1'b0;
            refund_q <= 1'b0;
            rcoins_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            coins_q  <= coins_d;
            timer_q  <= timer_d;
            occ_q    <= occ_d;
            exits_q  <= exits_d;
            gate_q   <= gate_d;
            green_q  <= green_d;
            red_q    <= red_d;
            hex1_q   <= hex1_d;
            hex2_q   <= hex2_d;
            reject_q <= reject_d;
            refund_q <= refund_d;
            rcoins_q <= rcoins_d;
        end
    end

    assign exit_io.gate_open    = gate_q;
    assign exit_io.green_light  = green_q;
    assign exit_io.red_light    = red_q;
    assign exit_io.hex_1        = hex1_q;
    assign exit_io.hex_2        = hex2_q;
    assign exit_io.occupancy    = occ_q;
    assign exit_io.full         = (occ_q == 4'(CAPACITY));
    assign exit_io.coin_reject  = reject_q;
    assign exit_io.refund       = refund_q;
    assign exit_io.refund_coins = rcoins_q;
    assign exit_io.exits_total  = exits_q;
endmodule

`default_nettype wire

// File: tb/tb_parking_exit_controller.sv
// ============================================================================
//  Module      : tb_parking_exit_controller
//  Description : Directed scenario bench for parking_exit_controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_parking_exit_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    localparam logic [6:0] H_OFF = 7'b0000000;
    localparam logic [6:0] H_P   = 7'b1110011;
    localparam logic [6:0] H_A   = 7'b1110111;
    localparam logic [6:0] H_6   = 7'b1111101;
    localparam logic [6:0] H_0   = 7'b0111111;
    localparam logic [6:0] H_L   = 7'b0111000;

    parking_exit_controller_if bif ();

    parking_exit_controller #(
        .CAPACITY(8), .FEE(3), .PAY_TIMEOUT(16), .GATE_OPEN_CYCLES(8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .exit_io (bif.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bif.entry_done = 0; bif.sense_exit = 0; bif.coin_valid = 0;
        bif.sense_clear = 0; bif.attendant_ack = 0;
        cyc(2);
        rst = 1'b0;
    endtask

    task automatic add_cars(input int n);
        bif.entry_done = 1'b1;
        cyc(n);
        bif.entry_done = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bif.gate_open !== 1'b0 || bif.green_light !== 1'b0 || bif.red_light !== 1'b0) begin errors++; $display("FAIL reset_lights got gate=%b green=%b red=%b want 000", bif.gate_open, bif.green_light, bif.red_light); end
        checks++; if (bif.hex_1 !== H_OFF || bif.hex_2 !== H_OFF) begin errors++; $display("FAIL reset_hex got %b/%b want 0000000/0000000", bif.hex_1, bif.hex_2); end
        checks++; if (bif.occupancy !== 4'd0 || bif.exits_total !== 16'd0 || bif.full !== 1'b0) begin errors++; $display("FAIL reset_counts got occ=%0d exits=%0d full=%b want 0 0 0", bif.occupancy, bif.exits_total, bif.full); end
        checks++; if (bif.refund !== 1'b0 || bif.coin_reject !== 1'b0) begin errors++; $display("FAIL reset_pulses got refund=%b reject=%b want 0 0", bif.refund, bif.coin_reject); end
    endtask

    task automatic test_paid_exit();
        add_cars(3);
        checks++; if (bif.occupancy !== 4'd3) begin errors++; $display("FAIL entry_count got %0d want 3", bif.occupancy); end
        bif.sense_exit = 1'b1;
        cyc();
        checks++; if (bif.hex_1 !== H_P || bif.hex_2 !== H_A || bif.gate_open !== 1'b0) begin errors++; $display("FAIL collect_entry got hex=%b/%b gate=%b want %b/%b 0", bif.hex_1, bif.hex_2, bif.gate_open, H_P, H_A); end
        bif.coin_valid = 1'b1;
        cyc(2);
        checks++; if (bif.gate_open !== 1'b0) begin errors++; $display("FAIL two_coins_gate got %b want 0", bif.gate_open); end
        cyc();
        bif.coin_valid = 1'b0;
        checks++; if (bif.gate_open !== 1'b1 || bif.green_light !== 1'b1 || bif.hex_1 !== H_6 || bif.hex_2 !== H_0) begin errors++; $display("FAIL open_entry got gate=%b green=%b hex=%b/%b want 1 1 %b/%b", bif.gate_open, bif.green_light, bif.hex_1, bif.hex_2, H_6, H_0); end
        cyc(2);
        checks++; if (bif.gate_open !== 1'b1) begin errors++; $display("FAIL open_dwell got %b want 1", bif.gate_open); end
        bif.sense_clear = 1'b1; bif.sense_exit = 1'b0;
        cyc();
        bif.sense_clear = 1'b0;
        checks++; if (bif.gate_open !== 1'b0 || bif.hex_1 !== H_OFF || bif.occupancy !== 4'd2 || bif.exits_total !== 16'd1) begin errors++; $display("FAIL exit_done got gate=%b hex1=%b occ=%0d exits=%0d want 0 0000000 2 1", bif.gate_open, bif.hex_1, bif.occupancy, bif.exits_total); end
    endtask

    task automatic test_backoff_refund();
        bif.sense_exit = 1'b1;
        cyc();
        bif.coin_valid = 1'b1;
        cyc();
        bif.coin_valid = 1'b0; bif.sense_exit = 1'b0;
        cyc();
        checks++; if (bif.refund !== 1'b1 || bif.refund_coins !== 4'd1 || bif.hex_1 !== H_OFF) begin errors++; $display("FAIL backoff_refund got refund=%b coins=%0d hex1=%b want 1 1 0000000", bif.refund, bif.refund_coins, bif.hex_1); end
        cyc();
        checks++; if (bif.refund !== 1'b0 || bif.occupancy !== 4'd2) begin errors++; $display("FAIL backoff_after got refund=%b occ=%0d want 0 2", bif.refund, bif.occupancy); end
    endtask

    task automatic test_pay_timeout();
        do_reset();
        add_cars(1);
        bif.sense_exit = 1'b1;
        cyc(16);
        checks++; if (bif.hex_1 !== H_P || bif.red_light !== 1'b0) begin errors++; $display("FAIL timeout_early got hex1=%b red=%b want %b 0", bif.hex_1, bif.red_light, H_P); end
        cyc();
        checks++; if (bif.red_light !== 1'b1 || bif.hex_1 !== H_A || bif.hex_2 !== H_L || bif.refund !== 1'b1 || bif.refund_coins !== 4'd0) begin errors++; $display("FAIL timeout_alarm got red=%b hex=%b/%b refund=%b coins=%0d want 1 %b/%b 1 0", bif.red_light, bif.hex_1, bif.hex_2, bif.refund, bif.refund_coins, H_A, H_L); end
        cyc();
        checks++; if (bif.red_light !== 1'b0 || bif.refund !== 1'b0) begin errors++; $display("FAIL blink_0 got red=%b refund=%b want 0 0", bif.red_light, bif.refund); end
        cyc();
        checks++; if (bif.red_light !== 1'b1) begin errors++; $display("FAIL blink_1 got %b want 1", bif.red_light); end
        bif.sense_exit = 1'b0; bif.attendant_ack = 1'b1;
        cyc();
        bif.attendant_ack = 1'b0;
        checks++; if (bif.red_light !== 1'b0 || bif.hex_1 !== H_OFF || bif.occupancy !== 4'd1) begin errors++; $display("FAIL ack_idle got red=%b hex1=%b occ=%0d want 0 0000000 1", bif.red_light, bif.hex_1, bif.occupancy); end
    endtask

    task automatic test_phantom_and_reject();
        do_reset();
        bif.sense_exit = 1'b1;
        cyc();
        bif.sense_exit = 1'b0;
        checks++; if (bif.red_light !== 1'b1 || bif.hex_1 !== H_A || bif.gate_open !== 1'b0) begin errors++; $display("FAIL phantom_alarm got red=%b hex1=%b gate=%b want 1 %b 0", bif.red_light, bif.hex_1, bif.gate_open, H_A); end
        bif.coin_valid = 1'b1;
        cyc();
        bif.coin_valid = 1'b0;
        checks++; if (bif.coin_reject !== 1'b1 || bif.refund !== 1'b0 || bif.hex_1 !== H_A) begin errors++; $display("FAIL alarm_reject got reject=%b refund=%b hex1=%b want 1 0 %b", bif.coin_reject, bif.refund, bif.hex_1, H_A); end
        cyc();
        checks++; if (bif.coin_reject !== 1'b0) begin errors++; $display("FAIL reject_pulse got %b want 0", bif.coin_reject); end
        bif.attendant_ack = 1'b1;
        cyc();
        bif.attendant_ack = 1'b0;
        bif.coin_valid = 1'b1;
        cyc();
        bif.coin_valid = 1'b0;
        checks++; if (bif.coin_reject !== 1'b1 || bif.hex_1 !== H_OFF) begin errors++; $display("FAIL idle_reject got reject=%b hex1=%b want 1 0000000", bif.coin_reject, bif.hex_1); end
    endtask

    task automatic test_full_saturation();
        do_reset();
        add_cars(8);
        checks++; if (bif.occupancy !== 4'd8 || bif.full !== 1'b1) begin errors++; $display("FAIL fill got occ=%0d full=%b want 8 1", bif.occupancy, bif.full); end
        add_cars(1);
        checks++; if (bif.occupancy !== 4'd8) begin errors++; $display("FAIL saturate got %0d want 8", bif.occupancy); end
        bif.sense_exit = 1'b1;
        cyc();
        bif.coin_valid = 1'b1;
        cyc(3);
        bif.coin_valid = 1'b0;
        bif.sense_clear = 1'b1; bif.entry_done = 1'b1; bif.sense_exit = 1'b0;
        cyc();
        bif.sense_clear = 1'b0; bif.entry_done = 1'b0;
        checks++; if (bif.occupancy !== 4'd8 || bif.full !== 1'b1 || bif.exits_total !== 16'd1 || bif.gate_open !== 1'b0) begin errors++; $display("FAIL swap_full got occ=%0d full=%b exits=%0d gate=%b want 8 1 1 0", bif.occupancy, bif.full, bif.exits_total, bif.gate_open); end
    endtask

    task automatic test_gate_timeout();
        do_reset();
        add_cars(2);
        bif.sense_exit = 1'b1;
        cyc();
        bif.coin_valid = 1'b1;
        cyc(3);
        bif.coin_valid = 1'b0;
        cyc(7);
        checks++; if (bif.gate_open !== 1'b1) begin errors++; $display("FAIL gate_last_cycle got %b want 1", bif.gate_open); end
        cyc();
        checks++; if (bif.gate_open !== 1'b0 || bif.red_light !== 1'b1 || bif.refund !== 1'b0 || bif.occupancy !== 4'd2 || bif.exits_total !== 16'd0) begin errors++; $display("FAIL gate_timeout got gate=%b red=%b refund=%b occ=%0d exits=%0d want 0 1 0 2 0", bif.gate_open, bif.red_light, bif.refund, bif.occupancy, bif.exits_total); end
        bif.sense_exit = 1'b0;
    endtask

    task automatic test_mid_reset();
        do_reset();
        add_cars(1);
        bif.sense_exit = 1'b1;
        cyc();
        bif.coin_valid = 1'b1;
        cyc(2);
        bif.coin_valid = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0; bif.sense_exit = 1'b0;
        checks++; if (bif.hex_1 !== H_OFF || bif.refund !== 1'b0 || bif.occupancy !== 4'd0) begin errors++; $display("FAIL reset_collect got hex1=%b refund=%b occ=%0d want 0000000 0 0", bif.hex_1, bif.refund, bif.occupancy); end
        cyc();
        checks++; if (bif.refund !== 1'b0) begin errors++; $display("FAIL reset_no_refund got %b want 0", bif.refund); end
        add_cars(1);
        bif.sense_exit = 1'b1;
        cyc();
        bif.coin_valid = 1'b1;
        cyc(3);
        bif.coin_valid = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0; bif.sense_exit = 1'b0;
        checks++; if (bif.gate_open !== 1'b0 || bif.green_light !== 1'b0 || bif.occupancy !== 4'd0 || bif.refund !== 1'b0) begin errors++; $display("FAIL reset_open got gate=%b green=%b occ=%0d refund=%b want 0 0 0 0", bif.gate_open, bif.green_light, bif.occupancy, bif.refund); end
    endtask

    initial begin
        test_reset();
        test_paid_exit();
        test_backoff_refund();
        test_pay_timeout();
        test_phantom_and_reject();
        test_full_saturation();
        test_gate_timeout();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
